// File: rtl/puf_response_gen.sv
// Ring-oscillator PUF response generator.
// Counts rising edges of two multiplexer-selected ring oscillators over equal
// windows. The response bit is 1 when oscillator A produced more edges than B.
// Optional feature: define PUF_TIE_DETECT_EN to add the 'tie' output, which
// flags equal counts.
module puf_response_gen #(
  parameter int CNT_W  = 16,
  parameter int WINDOW = 256,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       challenge,
  input  logic             ro_in,
  output logic [2:0]       sel,
  output logic             busy,
  output logic             done,
  output logic             response,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
`ifdef PUF_TIE_DETECT_EN
  ,
  output logic             tie
`endif
);

  // One down-counter times both settle and count phases, so size it for the longer one.
  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_A,
    COUNT_A,
    SETTLE_B,
    COUNT_B,
    COMPARE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [2:0]         chal_b_q, chal_b_d;
  logic [2:0]         sel_q, sel_d;
  // sync_q[0] is the metastability flop, sync_q[1] the synchronized value,
  // and sync_q[2] the previous synchronized value used for edge detection.
  logic [2:0]         sync_q, sync_d;
  logic [CNT_W-1:0]   cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]   cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0]   count_a_q, count_a_d;
  logic [CNT_W-1:0]   count_b_q, count_b_d;
  logic               resp_q, resp_d;
`ifdef PUF_TIE_DETECT_EN
  logic               tie_q, tie_d;
`endif
  logic               edge_det;

  assign edge_det = sync_q[1] & ~sync_q[2];

  // Sequencer: phase order, phase timer, challenge capture and mux select.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    chal_b_d = chal_b_q;
    sel_d    = sel_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SETTLE_A;
          tmr_d    = SETTLE_LD;
          chal_b_d = challenge[5:3];
          sel_d    = challenge[2:0];
        end
      end
      SETTLE_A: begin
        if (tmr_q == '0) begin
          state_d = COUNT_A;
          tmr_d   = WINDOW_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      COUNT_A: begin
        if (tmr_q == '0) begin
          state_d = SETTLE_B;
          tmr_d   = SETTLE_LD;
          sel_d   = chal_b_q;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      SETTLE_B: begin
        if (tmr_q == '0) begin
          state_d = COUNT_B;
          tmr_d   = WINDOW_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      COUNT_B: begin
        if (tmr_q == '0) begin
          state_d = COMPARE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      COMPARE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: synchronizer shift, saturating edge counters, result capture.
  always_comb begin
    sync_d    = {sync_q[1:0], ro_in};
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    count_a_d = count_a_q;
    count_b_d = count_b_q;
    resp_d    = resp_q;
`ifdef PUF_TIE_DETECT_EN
    tie_d     = tie_q;
`endif
    case (state_q)
      SETTLE_A: cnt_a_d = '0;
      COUNT_A: begin
        if (edge_det && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + 1'b1;
      end
      SETTLE_B: cnt_b_d = '0;
      COUNT_B: begin
        if (edge_det && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + 1'b1;
      end
      COMPARE: begin
        count_a_d = cnt_a_q;
        count_b_d = cnt_b_q;
        resp_d    = (cnt_a_q > cnt_b_q);
`ifdef PUF_TIE_DETECT_EN
        tie_d     = (cnt_a_q == cnt_b_q);
`endif
      end
      default: ;
    endcase
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      chal_b_q  <= '0;
      sel_q     <= '0;
      sync_q    <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      count_a_q <= '0;
      count_b_q <= '0;
      resp_q    <= 1'b0;
`ifdef PUF_TIE_DETECT_EN
      tie_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      chal_b_q  <= chal_b_d;
      sel_q     <= sel_d;
      sync_q    <= sync_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      count_a_q <= count_a_d;
      count_b_q <= count_b_d;
      resp_q    <= resp_d;
`ifdef PUF_TIE_DETECT_EN
      tie_q     <= tie_d;
`endif
    end
  end

  assign sel      = sel_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign response = resp_q;
  assign count_a  = count_a_q;
  assign count_b  = count_b_q;
`ifdef PUF_TIE_DETECT_EN
  assign tie      = tie_q;
`endif

endmodule
